// File: rtl/display_scanner_if.sv
// Pin-side bundle of the display scanner: the frame bus and controls coming in,
// the multiplexed 7-segment pins and frame marker going out.
interface display_scanner_if #(
  parameter int DEVICE_WIDTH   = 2,
  parameter int ENCODING_WIDTH = 7
);
  localparam int DEVICE_NUM = 2 ** DEVICE_WIDTH;

  logic [(ENCODING_WIDTH+1)*DEVICE_NUM-1:0] displays_flattened;
  logic                                     enable;
  logic [2:0]                               brightness;
  logic [ENCODING_WIDTH-1:0]                seg_n;
  logic                                     dp_n;
  logic [DEVICE_NUM-1:0]                    an_n;
  logic                                     frame_start;

  modport master (
    output displays_flattened, enable, brightness,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  displays_flattened, enable, brightness,
    output seg_n, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot blanking guard,
// 8-level brightness and a once-per-frame snapshot of the display bus.

// One digit lane: gates its word onto the shared pins while selected.
module display_scanner_digit #(
  parameter int ENCODING_WIDTH = 7
) (
  input  logic                      sel,
  input  logic [ENCODING_WIDTH:0]   word,
  output logic [ENCODING_WIDTH-1:0] seg,
  output logic                      dot
);
  // word MSB is the dot, active-low on the bus; segments are active-high
  assign seg = sel ? word[ENCODING_WIDTH-1:0] : '0;
  assign dot = sel & ~word[ENCODING_WIDTH];
endmodule

module display_scanner #(
  parameter int DEVICE_WIDTH   = 2,
  parameter int ENCODING_WIDTH = 7,
  parameter int SLOT_CYCLES    = 64,
  parameter int BLANK_CYCLES   = 4,
  parameter int ON_STEP        = 7
) (
  input logic              clk,
  input logic              rst,
  display_scanner_if.slave bus
);
  localparam int DEVICE_NUM = 2 ** DEVICE_WIDTH;
  localparam int WORD_W     = ENCODING_WIDTH + 1;
  localparam int CNT_W      = $clog2(SLOT_CYCLES);
  localparam int LEN_W      = CNT_W + 1;

  typedef enum logic [1:0] {BLANK, ON, OFF} state_t;

  state_t                              state, state_nxt;
  logic [CNT_W-1:0]                    slot_cnt, slot_nxt;
  logic [DEVICE_WIDTH-1:0]             idx, idx_nxt;
  logic [LEN_W-1:0]                    on_len, on_len_nxt, on_len_in, lit_end, slot_ext;
  logic [DEVICE_NUM-1:0][WORD_W-1:0]   snap, snap_nxt;
  logic                                run, run_nxt;
  logic                                snap_ld, fs_nxt;

  logic [DEVICE_NUM-1:0]                     sel;
  logic [DEVICE_NUM-1:0][ENCODING_WIDTH-1:0] seg_lane;
  logic [DEVICE_NUM-1:0]                     dot_lane;
  logic [ENCODING_WIDTH-1:0]                 seg_any;

  logic [ENCODING_WIDTH-1:0] seg_q;
  logic                      dp_q;
  logic [DEVICE_NUM-1:0]     an_q;
  logic                      fs_q;

  assign on_len_in = LEN_W'((int'(bus.brightness) + 1) * ON_STEP);
  assign lit_end   = LEN_W'(BLANK_CYCLES) + on_len_nxt;
  assign slot_ext  = LEN_W'(slot_nxt);
  assign snap_nxt  = snap_ld ? bus.displays_flattened : snap;

  // Counter/sequencing: run=0 means idle (after reset or a disable), and the
  // first enabled edge restarts a fresh frame with a new snapshot.
  always_comb begin
    run_nxt    = run;
    slot_nxt   = slot_cnt;
    idx_nxt    = idx;
    on_len_nxt = on_len;
    snap_ld    = 1'b0;
    fs_nxt     = 1'b0;
    if (!bus.enable) begin
      run_nxt  = 1'b0;
      slot_nxt = '0;
      idx_nxt  = '0;
    end else if (!run) begin
      run_nxt    = 1'b1;
      slot_nxt   = '0;
      idx_nxt    = '0;
      on_len_nxt = on_len_in;
      snap_ld    = 1'b1;
      fs_nxt     = 1'b1;
    end else if (slot_cnt == CNT_W'(SLOT_CYCLES - 1)) begin
      slot_nxt   = '0;
      idx_nxt    = idx + DEVICE_WIDTH'(1);
      on_len_nxt = on_len_in;
      snap_ld    = (idx == '1);
      fs_nxt     = (idx == '1);
    end else begin
      slot_nxt = slot_cnt + CNT_W'(1);
    end
  end

  // Slot FSM evaluated on the next count so the registered pins line up with
  // the state of the cycle they are shown in.
  always_comb begin
    state_nxt = state;
    if (!bus.enable || !run || slot_nxt == '0) begin
      state_nxt = BLANK;
    end else begin
      case (state)
        BLANK:   if (slot_ext >= LEN_W'(BLANK_CYCLES)) state_nxt = ON;
        ON:      if (slot_ext >= lit_end) state_nxt = OFF;
        OFF:     state_nxt = OFF;
        default: state_nxt = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BLANK;
    else      state <= state_nxt;
  end

  assign sel = (state_nxt == ON) ? (DEVICE_NUM'(1) << idx_nxt) : '0;

  for (genvar j = 0; j < DEVICE_NUM; j++) begin : g_digit
    display_scanner_digit #(.ENCODING_WIDTH(ENCODING_WIDTH)) u_digit (
      .sel  (sel[j]),
      .word (snap_nxt[j]),
      .seg  (seg_lane[j]),
      .dot  (dot_lane[j])
    );
  end

  always_comb begin
    seg_any = '0;
    for (int j = 0; j < DEVICE_NUM; j++) seg_any |= seg_lane[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      idx      <= '0;
      run      <= 1'b0;
      on_len   <= LEN_W'(ON_STEP);
      snap     <= {DEVICE_NUM{1'b1, {ENCODING_WIDTH{1'b0}}}};
      seg_q    <= '1;
      dp_q     <= 1'b1;
      an_q     <= '1;
      fs_q     <= 1'b0;
    end else begin
      slot_cnt <= slot_nxt;
      idx      <= idx_nxt;
      run      <= run_nxt;
      on_len   <= on_len_nxt;
      snap     <= snap_nxt;
      seg_q    <= ~seg_any;
      dp_q     <= ~(|dot_lane);
      an_q     <= ~sel;
      fs_q     <= fs_nxt;
    end
  end

  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.an_n        = an_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: scan timing, brightness, snapshot,
// enable restart and asynchronous reset.
module tb_display_scanner;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  display_scanner_if #(.DEVICE_WIDTH(2), .ENCODING_WIDTH(7)) dut_if ();

  display_scanner #(
    .DEVICE_WIDTH(2), .ENCODING_WIDTH(7), .SLOT_CYCLES(64), .BLANK_CYCLES(4), .ON_STEP(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pins(input string tag, input logic [3:0] an, input logic [6:0] seg,
                      input logic dp, input logic fs);
    chk({tag, ".an_n"}, 32'(dut_if.an_n), 32'(an));
    chk({tag, ".seg_n"}, 32'(dut_if.seg_n), 32'(seg));
    chk({tag, ".dp_n"}, 32'(dut_if.dp_n), 32'(dp));
    chk({tag, ".frame_start"}, 32'(dut_if.frame_start), 32'(fs));
  endtask

  task automatic dark(input string tag, input logic fs);
    pins(tag, 4'hF, 7'h7F, 1'b1, fs);
  endtask

  // advance to the negedge of frame cycle k (cycle 0 follows the restart edge)
  task automatic adv(input int k);
    repeat (k - cur) @(negedge clk);
    cur = k;
  endtask

  initial begin
    rst = 1'b1;
    dut_if.enable = 1'b1;
    dut_if.brightness = 3'd7;
    dut_if.displays_flattened = 32'h664F5B06;
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      dark("reset", 1'b0);
    end
    rst = 1'b1;
    @(negedge clk); cur = 0;

    // static frame, brightness 7
    dark("f0_c0", 1'b1);
    adv(3);   dark("f0_c3", 1'b0);
    adv(4);   pins("s0_c4", 4'hE, 7'h79, 1'b0, 1'b0);
    adv(59);  pins("s0_c59", 4'hE, 7'h79, 1'b0, 1'b0);
    adv(60);  dark("s0_c60", 1'b0);
    adv(63);  dark("s0_c63", 1'b0);
    adv(68);  pins("s1_c4", 4'hD, 7'h24, 1'b0, 1'b0);
    adv(123); pins("s1_c59", 4'hD, 7'h24, 1'b0, 1'b0);
    adv(124); dark("s1_c60", 1'b0);
    adv(132); pins("s2_c4", 4'hB, 7'h30, 1'b0, 1'b0);
    adv(196); pins("s3_c4", 4'h7, 7'h19, 1'b0, 1'b0);
    adv(255); dark("f0_last", 1'b0);
    adv(256); dark("f1_c0", 1'b1);

    // brightness 0 from the next slot, then 3 from mid-slot
    adv(300); dut_if.brightness = 3'd0;
    adv(301); pins("b0_cur_slot", 4'hE, 7'h79, 1'b0, 1'b0);
    adv(320); dark("b0_c0", 1'b0);
    adv(324); pins("b0_c4", 4'hD, 7'h24, 1'b0, 1'b0);
    adv(330); pins("b0_c10", 4'hD, 7'h24, 1'b0, 1'b0);
    adv(331); dark("b0_c11", 1'b0);
    adv(340); dut_if.brightness = 3'd3;
    adv(341); dark("b3_cur_slot", 1'b0);
    adv(388); pins("b3_c4", 4'hB, 7'h30, 1'b0, 1'b0);
    adv(415); pins("b3_c31", 4'hB, 7'h30, 1'b0, 1'b0);
    adv(416); dark("b3_c32", 1'b0);

    // tearing: word 2 changed during slot 1
    adv(512); dark("f2_c0", 1'b1);
    adv(586); dut_if.displays_flattened[16 +: 8] = 8'h7F;
    adv(644); pins("tear_old", 4'hB, 7'h30, 1'b0, 1'b0);
    adv(768); dark("f3_c0", 1'b1);
    adv(900); pins("tear_new", 4'hB, 7'h00, 1'b0, 1'b0);

    // enable drop mid-ON, restart with fresh snapshot
    dut_if.enable = 1'b0;
    adv(901); dark("dis_next", 1'b0);
    dut_if.displays_flattened[0 +: 8] = 8'h3F;
    adv(905); dark("dis_hold", 1'b0);
    dut_if.enable = 1'b1;
    @(negedge clk); cur = 0;
    dark("re_c0", 1'b1);
    adv(3);  dark("re_c3", 1'b0);
    adv(4);  pins("re_c4", 4'hE, 7'h40, 1'b0, 1'b0);
    adv(10); pins("re_c10", 4'hE, 7'h40, 1'b0, 1'b0);

    // asynchronous reset mid-ON, between edges
    rst = 1'b0;
    #1 dark("arst_now", 1'b0);
    dut_if.brightness = 3'd7;
    dut_if.displays_flattened[0 +: 8] = 8'h07;
    @(negedge clk); dark("arst_hold", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); cur = 0;
    dark("rr_c0", 1'b1);
    adv(4);   pins("rr_c4", 4'hE, 7'h78, 1'b0, 1'b0);
    adv(59);  pins("rr_c59", 4'hE, 7'h78, 1'b0, 1'b0);
    adv(60);  dark("rr_c60", 1'b0);
    adv(256); dark("rr_f1", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Physical-side consumer of the per-device display bus (`displays_flattened`) produced by the device-array top level.
- Time-multiplexes DEVICE_NUM 8-bit display words ({dot, seg[6:0]}) onto a single common-anode 7-segment pin set with one-hot active-low digit enables.
- Inserts a blanking guard at the start of every digit slot and applies 8-level brightness control.
- Latches the whole bus once per scan frame so a frame never tears.

Parameters:
- DEVICE_WIDTH, 2, log2 of the number of digits; DEVICE_NUM = 2**DEVICE_WIDTH.
- ENCODING_WIDTH, 7, segment bits per digit; word width is ENCODING_WIDTH+1.
- SLOT_CYCLES, 64, clocks per digit slot.
- BLANK_CYCLES, 4, guard clocks at the start of each slot, all pins dark.
- ON_STEP, 7, lit clocks per brightness step. Constraint: BLANK_CYCLES + 8*ON_STEP <= SLOT_CYCLES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- displays_flattened  in  (ENCODING_WIDTH+1)*DEVICE_NUM  word j at bits [j*8 +: 8].
  - Bit 7 of each word is dot, active-low (0 = lit).
  - Bits 6:0 are segments, active-high (1 = lit).
- enable  in  1  0 = scanning halted, pins dark.
- brightness  in  3  lit length = (brightness+1)*ON_STEP clocks per slot.
- seg_n  out  ENCODING_WIDTH  segment pins, active-low.
- dp_n  out  1  dot pin, active-low.
- an_n  out  DEVICE_NUM  digit enables, active-low, at most one low.
- frame_start  out  1  one-clock pulse at start of each frame.

Behaviour:
- Registers:
  - slot_cnt, 0..SLOT_CYCLES-1.
  - idx, DEVICE_WIDTH bits.
  - on_len, sampled brightness.
  - snap, frame snapshot of the full bus.
  - state.
- Reset (rst=0, async):
  - slot_cnt=0, idx=0, state=BLANK.
  - seg_n all 1, dp_n=1, an_n all 1, frame_start=0.
  - snap all-dark: segments 0, dots 1.
- slot_cnt increments each clock.
  - At SLOT_CYCLES-1 it wraps to 0 and idx increments.
  - idx wraps DEVICE_NUM-1 -> 0.
- Snapshot:
  - snap <= displays_flattened on the clock edge that makes slot_cnt=0 and idx=0, i.e. frame wrap.
  - Also on the first edge after reset release, and on the first edge with enable=1 after enable=0.
  - Bus changes inside a frame are invisible until the next frame.
- on_len is sampled on the same edge that makes slot_cnt=0; mid-slot brightness changes apply from the next slot.
- States, as a function of the registered slot_cnt for the current cycle:
  - BLANK: slot_cnt in [0, BLANK_CYCLES).
  - ON: slot_cnt in [BLANK_CYCLES, BLANK_CYCLES+on_len).
  - OFF: remainder of the slot.
- Outputs are registered, glitch-free, and aligned to the state of the same cycle:
  - BLANK/OFF: an_n all 1, seg_n all 1, dp_n=1.
  - ON: an_n = ~(1<<idx), seg_n = ~snap[idx][6:0], dp_n = snap[idx][7].
- frame_start=1 exactly in cycles with idx=0, slot_cnt=0, enable=1. Frame period = DEVICE_NUM*SLOT_CYCLES clocks.
- enable=0 (synchronous):
  - Next edge forces slot_cnt=0, idx=0, state=BLANK, pins dark, frame_start=0.
  - After re-enable, scanning restarts from digit 0 with a fresh snapshot.
- Async reset mid-ON darkens pins immediately, with no clock required.
- brightness=7 at default parameters: lit 56, dark 8 clocks per slot; maximum duty is bounded by the parameter constraint.
- No combinational path from inputs to pins.

Test Plan:
- Reset: hold rst=0 for 5 clocks -> an_n=4'b1111, seg_n=7'h7F, dp_n=1, frame_start=0 throughout.
- Static frame: bus words 0..3 = 8'h06, 8'h5B, 8'h4F, 8'h66, brightness=7, enable=1 ->
  - Slot0 cycles 4..59: an_n=1110, seg_n=7'b1111001, dp_n=0.
  - Cycles 0..3 and 60..63: dark.
  - Slot1 cycles 4..59: an_n=1101, seg_n=7'b0100100.
  - frame_start pulses every 256 clocks.
- Brightness 0: ON only on slot cycles 4..10 (7 clocks). Switch to 3 at slot cycle 20 -> current slot unchanged; next slot lit cycles 4..31.
- Tearing: change word 2 to 8'h7F during slot 1 -> slot 2 still shows 8'h4F; the new value appears only after the next frame_start.
- enable drop mid-ON of slot 2 -> pins dark on the next clock. Re-enable -> frame_start on the first enabled cycle, digit 0 shown at cycle 4.
- Async reset asserted mid-ON between clock edges -> an_n=1111 before the next edge. After release, a full frame restarts at digit 0 with the snapshot taken on the first edge.
